flow_quant_sched: RTL and testbench
===================================

// Module: flow_quant_sched
// PURPOSE
//  - Quantization scheduler that sits directly in front of flow_divider on the JPEG coefficient flow.
//  - Re-times the coefficient stream by one cycle and attaches the quantizer denominator for every lane.
//  - The denominator comes from a per-component quant table, selected by position in the 8x8 block and by block index in the MCU.
//  - Tables are written through a shadow bank and take effect atomically at the next start of frame.
// PARAMETERS
//  N      2  lanes per beat; must divide 64
//  MCU_Y  4  luma blocks per MCU; each MCU is MCU_Y luma blocks followed by 2 chroma blocks
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        reset, asynchronous, active-low
//  en          in   1        global clock enable; when low, all state and outputs hold
//  in_valid    in   1        input beat valid
//  in_data     in   N*16     signed coefficients, lane i = coefficient beat*N+i
//  in_sob      in   1        start of block (first beat)
//  in_eob      in   1        end of block (last beat)
//  in_sof      in   1        start of frame (coincides with sob of first block)
//  cfg_we      in   1        shadow table write strobe
//  cfg_tab     in   1        table select: 0 = luma, 1 = chroma
//  cfg_addr    in   6        coefficient index, 0..63
//  cfg_data    in   10       unsigned denominator
//  cfg_commit  in   1        request shadow->active copy at next accepted sof
//  out_valid   out  1        registered in_valid
//  out_data    out  N*16     registered in_data
//  out_denom   out  N*10     denominator per lane, feeds flow_divider in_denom
//  out_sob/out_eob/out_sof  out  1  registered markers
//  cfg_pending out  1        commit requested, not yet applied
//  err_len     out  1        sticky: block length != 64/N beats
// BEHAVIOUR
//  - Reset values:
//    - All outputs 0.
//    - Active and shadow tables all entries = 1 (pass-through).
//    - beat_cnt = 0, blk_cnt = 0, pending = 0.
//  - State changes only on cycles with en=1. "Accepted beat" means en & in_valid.
//  - Latency: exactly 1 enabled cycle from input to output for data, markers and valid.
//  - out_denom is updated only on accepted beats; when in_valid=0, out_denom holds its last value.
//  - beat_cnt:
//    - Lane index = beat*N+i, where beat is in_sob ? 0 : beat_cnt.
//    - On an accepted beat: beat_cnt <= (in_eob ? 0 : beat+1).
//    - beat_cnt saturates at 64/N-1 and never wraps into the next block.
//  - err_len:
//    - Set on an accepted eob when beat != 64/N-1.
//    - Set on an accepted non-eob beat when beat == 64/N-1.
//    - Cleared only by an accepted sof. If sof and the error condition fall in the same beat, set wins.
//  - blk_cnt (0..MCU_Y+1):
//    - Table select = (blk_cnt < MCU_Y) ? 0 : 1.
//    - An accepted sob that is not sof uses and keeps the current blk_cnt.
//    - An accepted eob increments blk_cnt; MCU_Y+1 wraps to 0.
//    - An accepted sof forces blk_cnt to 0 for that beat.
//  - Config:
//    - cfg_we writes the shadow table immediately; it is accepted regardless of en.
//    - cfg_data == 0 is stored as 1, so divide-by-zero can never reach the divider.
//    - cfg_commit sets pending, regardless of en.
//    - An accepted sof with pending set, or with cfg_commit high in the same cycle, copies both shadow tables to active and clears pending.
//    - The copy uses shadow contents as of the start of that cycle. A same-cycle cfg_we lands in shadow only.
//    - The sof beat itself is looked up in the newly copied tables.
//  - A reset asserted mid-block discards the block. The first post-reset block must start with sob.
// STRUCTURE
//  - jpeg_pkg holds:
//    - BLK_SIZE=64, DATA_W=16, DENOM_W=10
//    - typedef logic [DENOM_W-1:0] denom_t
//    - typedef denom_t [BLK_SIZE-1:0] qtab_t
//  - Sub-module qtab_regs: shadow and active qtab_t banks for 2 tables, write port, commit copy, and N combinational read ports.
//  - Top level: counters, marker/data register stage, error and pending flags.
// TESTING
//  - Default tables after reset: one sof block of 32 beats, data 100 -> out_denom all 1, out_data 100, markers delayed exactly 1 cycle.
//  - Load luma[k]=k+1 and commit -> no effect before sof. On the next sof block, beat b lane i -> out_denom = 2b+i+1.
//  - luma all 3, chroma all 7, 7 blocks after sof -> per-block denominators 3,3,3,3,7,7,3.
//  - en=0 for 5 cycles mid-block -> outputs frozen; the sequence resumes at the same index with no skipped or duplicated index.
//  - eob at beat 20 -> err_len=1; next sob restarts at index 0; next sof clears err_len.
//  - Write cfg_data=0 to addr 5, commit, sof -> index 5 denominator = 1. cfg_commit coincident with sof -> applied on that beat, cfg_pending stays 0.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG coefficient-path constants, quant table types and helpers.
package jpeg_pkg;

  localparam int unsigned BLK_SIZE = 64;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned DENOM_W  = 10;
  localparam int unsigned IDX_W    = 6;

  typedef logic [DENOM_W-1:0] denom_t;
  typedef denom_t [BLK_SIZE-1:0] qtab_t;

  // A zero denominator is promoted to 1 so the divider never sees it.
  function automatic denom_t sanitize_denom(input denom_t d);
    return (d == '0) ? denom_t'(1) : d;
  endfunction

  function automatic qtab_t unity_tab();
    qtab_t t;
    for (int k = 0; k < int'(BLK_SIZE); k++) t[k] = denom_t'(1);
    return t;
  endfunction

endpackage

// File: rtl/qtab_regs.sv
// Shadow/active quant table banks (luma, chroma) with atomic commit and N read ports.
module qtab_regs
  import jpeg_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic                        wr_tab,
  input  logic [IDX_W-1:0]            wr_addr,
  input  denom_t                      wr_data,
  input  logic                        commit,
  input  logic                        rd_tab,
  input  logic [N-1:0][IDX_W-1:0]     rd_idx,
  output denom_t [N-1:0]              rd_denom_c
);

  qtab_t shadow_q [2];
  qtab_t shadow_d [2];
  qtab_t active_q [2];
  qtab_t active_d [2];

  // Commit copies the pre-write shadow; a same-cycle write lands in shadow only.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (commit) active_d = shadow_q;
    if (wr_en) shadow_d[wr_tab][wr_addr] = sanitize_denom(wr_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < 2; t++) begin
        shadow_q[t] <= unity_tab();
        active_q[t] <= unity_tab();
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // The committing beat already sees the tables it is about to install.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      rd_denom_c[i] = commit ? shadow_q[rd_tab][rd_idx[i]] : active_q[rd_tab][rd_idx[i]];
    end
  end

endmodule

// File: rtl/flow_quant_sched.sv
// Quantization scheduler: re-times the coefficient stream one cycle and attaches per-lane denominators.
module flow_quant_sched
  import jpeg_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned MCU_Y = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [N*DATA_W-1:0]      in_data,
  input  logic                     in_sob,
  input  logic                     in_eob,
  input  logic                     in_sof,
  input  logic                     cfg_we,
  input  logic                     cfg_tab,
  input  logic [IDX_W-1:0]         cfg_addr,
  input  logic [DENOM_W-1:0]       cfg_data,
  input  logic                     cfg_commit,
  output logic                     out_valid,
  output logic [N*DATA_W-1:0]      out_data,
  output logic [N*DENOM_W-1:0]     out_denom,
  output logic                     out_sob,
  output logic                     out_eob,
  output logic                     out_sof,
  output logic                     cfg_pending,
  output logic                     err_len
);

  localparam int unsigned BEATS     = BLK_SIZE / N;
  localparam int unsigned LAST_BEAT = BEATS - 1;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BLK_W     = $clog2(MCU_Y + 2);

  logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [BLK_W-1:0]           blk_cnt_q, blk_cnt_d;
  logic                       pending_q, pending_d;
  logic                       err_q, err_d;
  logic                       valid_q, valid_d;
  logic [N*DATA_W-1:0]        data_q, data_d;
  logic [N*DENOM_W-1:0]       denom_q, denom_d;
  logic                       sob_q, sob_d;
  logic                       eob_q, eob_d;
  logic                       sof_q, sof_d;

  logic                       accept_c;
  logic                       commit_c;
  logic                       last_c;
  logic                       rd_tab_c;
  logic [BEAT_W-1:0]          beat_c;
  logic [BLK_W-1:0]           blk_c;
  logic [N-1:0][IDX_W-1:0]    rd_idx_c;
  denom_t [N-1:0]             rd_denom_c;

  // Effective beat/block position of the current input beat.
  always_comb begin
    accept_c = en & in_valid;
    beat_c   = in_sob ? '0 : beat_cnt_q;
    blk_c    = in_sof ? '0 : blk_cnt_q;
    last_c   = (beat_c == BEAT_W'(LAST_BEAT));
    commit_c = accept_c & in_sof & (pending_q | cfg_commit);
    rd_tab_c = (blk_c >= BLK_W'(MCU_Y));
    for (int i = 0; i < int'(N); i++) begin
      rd_idx_c[i] = IDX_W'(int'(beat_c) * int'(N) + i);
    end
  end

  qtab_regs #(.N(N)) u_qtab (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (cfg_we),
    .wr_tab     (cfg_tab),
    .wr_addr    (cfg_addr),
    .wr_data    (cfg_data),
    .commit     (commit_c),
    .rd_tab     (rd_tab_c),
    .rd_idx     (rd_idx_c),
    .rd_denom_c (rd_denom_c)
  );

  // Next-state: counters, flags and the output register stage.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    pending_d  = pending_q;
    err_d      = err_q;
    valid_d    = valid_q;
    data_d     = data_q;
    denom_d    = denom_q;
    sob_d      = sob_q;
    eob_d      = eob_q;
    sof_d      = sof_q;

    if (commit_c)        pending_d = 1'b0;
    else if (cfg_commit) pending_d = 1'b1;

    if (en) begin
      valid_d = in_valid;
      data_d  = in_data;
      sob_d   = in_sob;
      eob_d   = in_eob;
      sof_d   = in_sof;
    end

    if (accept_c) begin
      denom_d = rd_denom_c;
      if (in_eob)      beat_cnt_d = '0;
      else if (last_c) beat_cnt_d = beat_c;
      else             beat_cnt_d = beat_c + BEAT_W'(1);
      if (in_eob) blk_cnt_d = (blk_c == BLK_W'(MCU_Y + 1)) ? '0 : blk_c + BLK_W'(1);
      else        blk_cnt_d = blk_c;
      // A length error on the sof beat itself survives the sof clear.
      err_d = (in_eob ? !last_c : last_c) | (err_q & !in_sof);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      blk_cnt_q  <= '0;
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      denom_q    <= '0;
      sob_q      <= 1'b0;
      eob_q      <= 1'b0;
      sof_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      denom_q    <= denom_d;
      sob_q      <= sob_d;
      eob_q      <= eob_d;
      sof_q      <= sof_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_denom   = denom_q;
  assign out_sob     = sob_q;
  assign out_eob     = eob_q;
  assign out_sof     = sof_q;
  assign cfg_pending = pending_q;
  assign err_len     = err_q;

endmodule

// File: tb/tb_flow_quant_sched.sv
// Directed and randomized bench for flow_quant_sched against a table/counter reference model.
module tb_flow_quant_sched;

  localparam int N     = 2;
  localparam int MCU_Y = 4;
  localparam int BEATS = 64 / N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, in_valid = 1'b0, in_sob = 1'b0, in_eob = 1'b0, in_sof = 1'b0;
  logic [31:0] in_data = '0;
  logic        cfg_we = 1'b0, cfg_tab = 1'b0, cfg_commit = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [9:0]  cfg_data = '0;
  logic        out_valid, out_sob, out_eob, out_sof, cfg_pending, err_len;
  logic [31:0] out_data;
  logic [19:0] out_denom;

  always #5 clk = ~clk;

  flow_quant_sched #(.N(N), .MCU_Y(MCU_Y)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
    .cfg_we(cfg_we), .cfg_tab(cfg_tab), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit),
    .out_valid(out_valid), .out_data(out_data), .out_denom(out_denom),
    .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof),
    .cfg_pending(cfg_pending), .err_len(err_len)
  );

  // Reference model state
  int          sh [2][64];
  int          act[2][64];
  int          m_beat, m_blk;
  bit          m_pend, m_err;
  logic        e_valid, e_sob, e_eob, e_sof;
  logic [31:0] e_data;
  logic [19:0] e_denom;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int t = 0; t < 2; t++)
      for (int k = 0; k < 64; k++) begin
        sh[t][k]  = 1;
        act[t][k] = 1;
      end
    m_beat = 0; m_blk = 0; m_pend = 1'b0; m_err = 1'b0;
    e_valid = 1'b0; e_sob = 1'b0; e_eob = 1'b0; e_sof = 1'b0;
    e_data = '0; e_denom = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, "_data"}, out_data, e_data);
    chk({tag, "_denom"}, 32'(out_denom), 32'(e_denom));
    chk({tag, "_mark"}, 32'({out_sob, out_eob, out_sof}), 32'({e_sob, e_eob, e_sof}));
    chk({tag, "_pend"}, 32'(cfg_pending), 32'(m_pend));
    chk({tag, "_err"}, 32'(err_len), 32'(m_err));
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic drive(input bit e, input bit v, input bit sob, input bit eob, input bit sof,
                       input bit we, input bit tab, input int addr, input int cd,
                       input bit cm, input logic [31:0] d);
    int b, bk, t;
    bit applied, last;
    en = e; in_valid = v; in_sob = sob; in_eob = eob; in_sof = sof; in_data = d;
    cfg_we = we; cfg_tab = tab; cfg_addr = 6'(addr); cfg_data = 10'(cd); cfg_commit = cm;
    applied = 1'b0;
    if (e) begin
      e_valid = v; e_data = d; e_sob = sob; e_eob = eob; e_sof = sof;
    end
    if (e && v) begin
      b  = sob ? 0 : m_beat;
      bk = sof ? 0 : m_blk;
      if (sof && (m_pend || cm)) begin
        act = sh;
        m_pend = 1'b0;
        applied = 1'b1;
      end
      t = (bk < MCU_Y) ? 0 : 1;
      for (int i = 0; i < N; i++) e_denom[i*10 +: 10] = 10'(act[t][b*N+i]);
      last = (b == BEATS - 1);
      m_err  = (eob ? !last : last) || (m_err && !sof);
      m_beat = eob ? 0 : (last ? b : b + 1);
      m_blk  = eob ? ((bk == MCU_Y + 1) ? 0 : bk + 1) : bk;
    end
    if (cm && !applied) m_pend = 1'b1;
    if (we) sh[tab][addr[5:0]] = (cd % 1024 == 0) ? 1 : cd % 1024;
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic beat(input bit sob, input bit eob, input bit sof, input logic [31:0] d);
    drive(1'b1, 1'b1, sob, eob, sof, 1'b0, 1'b0, 0, 0, 1'b0, d);
  endtask

  task automatic cfg(input bit tab, input int addr, input int cd);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tab, addr, cd, 1'b0, '0);
  endtask

  task automatic commit_req();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, '0);
  endtask

  task automatic send_block(input bit sof, input int len);
    for (int b = 0; b < len; b++) beat(b == 0, b == len - 1, sof && b == 0, $urandom);
  endtask

  task automatic hw_reset();
    rst_n = 1'b0;
    en = 1'b0; in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    cfg_we = 1'b0; cfg_commit = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_denom", 32'(out_denom), 32'd0);
    chk("rst_mark", 32'({out_sob, out_eob, out_sof}), 32'd0);
    chk("rst_pend", 32'(cfg_pending), 32'd0);
    chk("rst_err", 32'(err_len), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int blk_exp[7];
    logic [31:0] held;
    int pos, len;
    bit sofsel;
    blk_exp = '{3, 3, 3, 3, 7, 7, 3};

    hw_reset();

    // Default tables: pass-through denominators, markers delayed one cycle.
    for (int b = 0; b < BEATS; b++) begin
      beat(b == 0, b == BEATS - 1, b == 0, {16'd100, 16'd100});
      chk("dflt_denom", 32'(out_denom), {12'd0, 10'd1, 10'd1});
      chk("dflt_data", out_data, {16'd100, 16'd100});
      chk("dflt_sof", 32'(out_sof), 32'(b == 0));
    end

    // Ramp luma table; commit waits for the next sof.
    for (int k = 0; k < 64; k++) cfg(1'b0, k, k + 1);
    commit_req();
    chk("ramp_pending", 32'(cfg_pending), 32'd1);
    for (int b = 0; b < BEATS; b++) begin
      beat(b == 0, b == BEATS - 1, 1'b0, $urandom);
      chk("ramp_nosof", 32'(out_denom), {12'd0, 10'd1, 10'd1});
    end
    for (int b = 0; b < BEATS; b++) begin
      beat(b == 0, b == BEATS - 1, b == 0, $urandom);
      chk("ramp_denom", 32'(out_denom), {12'd0, 10'(2*b + 2), 10'(2*b + 1)});
    end
    chk("ramp_applied", 32'(cfg_pending), 32'd0);

    // Luma 3 / chroma 7 across an MCU plus one block.
    for (int k = 0; k < 64; k++) begin
      cfg(1'b0, k, 3);
      cfg(1'b1, k, 7);
    end
    commit_req();
    for (int blk = 0; blk < 7; blk++)
      for (int b = 0; b < BEATS; b++) begin
        beat(b == 0, b == BEATS - 1, blk == 0 && b == 0, $urandom);
        chk("mcu_denom", 32'(out_denom), {12'd0, 10'(blk_exp[blk]), 10'(blk_exp[blk])});
      end

    // Clock-enable freeze mid-block.
    for (int k = 0; k < 64; k++) cfg(1'b0, k, k + 1);
    commit_req();
    for (int b = 0; b < BEATS; b++) begin
      beat(b == 0, b == BEATS - 1, b == 0, $urandom);
      chk("freeze_idx", 32'(out_denom), {12'd0, 10'(2*b + 2), 10'(2*b + 1)});
      if (b == 10) begin
        held = out_data;
        for (int f = 0; f < 5; f++) begin
          drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, $urandom);
          chk("freeze_data", out_data, held);
          chk("freeze_denom", 32'(out_denom), {12'd0, 10'd22, 10'd21});
        end
      end
    end

    // Short block sets err_len; next sob restarts at index 0; next sof clears.
    send_block(1'b0, 21);
    chk("err_set", 32'(err_len), 32'd1);
    beat(1'b1, 1'b0, 1'b0, $urandom);
    chk("err_restart", 32'(out_denom), {12'd0, 10'd2, 10'd1});
    for (int b = 1; b < BEATS; b++) beat(1'b0, b == BEATS - 1, 1'b0, $urandom);
    chk("err_sticky", 32'(err_len), 32'd1);
    beat(1'b1, 1'b0, 1'b1, $urandom);
    chk("err_clear", 32'(err_len), 32'd0);
    for (int b = 1; b < BEATS; b++) beat(1'b0, b == BEATS - 1, 1'b0, $urandom);

    // Zero denominator is stored as 1.
    cfg(1'b0, 5, 0);
    commit_req();
    for (int b = 0; b < BEATS; b++) begin
      beat(b == 0, b == BEATS - 1, b == 0, $urandom);
      if (b == 2) chk("zero_denom", 32'(out_denom), {12'd0, 10'd1, 10'd5});
    end

    // Commit coincident with sof applies on that very beat.
    cfg(1'b0, 5, 9);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, $urandom);
    chk("coin_pending", 32'(cfg_pending), 32'd0);
    for (int b = 1; b < BEATS; b++) begin
      beat(1'b0, b == BEATS - 1, 1'b0, $urandom);
      if (b == 2) chk("coin_denom", 32'(out_denom), {12'd0, 10'd9, 10'd5});
    end

    // Randomized traffic with config churn, gaps, bad lengths and one reset.
    pos = 0; len = BEATS; sofsel = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit e, v, we, cm;
      if (cyc == 1500) begin
        hw_reset();
        pos = 0;
      end
      if (pos == 0) begin
        len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, BEATS + 2)) : BEATS;
        sofsel = ($urandom_range(0, 5) == 0);
      end
      e  = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 3) == 0);
      cm = ($urandom_range(0, 29) == 0);
      drive(e, v, pos == 0, pos == len - 1, sofsel && pos == 0, we, 1'($urandom),
            int'($urandom_range(0, 63)), int'($urandom_range(0, 15)), cm, $urandom);
      if (e && v) pos = (pos == len - 1) ? 0 : pos + 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
